// File: rtl/pxs_pkg.sv
// ---------------------------------------------------------------------------
// pxs_pkg
//   Shared definitions for the 26-bit pixel stream:
//     [25]    VS
//     [24]    HS
//     [23:16] R
//     [15:8]  G
//     [7:0]   B
//   Also holds the delay-line FSM state type and a small field-packing helper.
// ---------------------------------------------------------------------------
package pxs_pkg;

    localparam int PXS_W      = 26;
    localparam int PXS_VS_BIT = 25;
    localparam int PXS_HS_BIT = 24;
    localparam int PXS_R_HI   = 23;
    localparam int PXS_R_LO   = 16;
    localparam int PXS_G_HI   = 15;
    localparam int PXS_G_LO   = 8;
    localparam int PXS_B_HI   = 7;
    localparam int PXS_B_LO   = 0;

    typedef logic [PXS_W-1:0] pxs_t;

    // Blank word: black pixel with both syncs inactive.
    localparam pxs_t PXS_BLANK = '0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FILL = 1'b1
    } dly_state_e;

    function automatic pxs_t pxs_pack(input logic       vs,
                                      input logic       hs,
                                      input logic [7:0] r,
                                      input logic [7:0] g,
                                      input logic [7:0] b);
        pxs_t w;
        w                      = '0;
        w[PXS_VS_BIT]          = vs;
        w[PXS_HS_BIT]          = hs;
        w[PXS_R_HI:PXS_R_LO]   = r;
        w[PXS_G_HI:PXS_G_LO]   = g;
        w[PXS_B_HI:PXS_B_LO]   = b;
        return w;
    endfunction

endpackage

// File: rtl/pxs_delay_align_if.sv
// ---------------------------------------------------------------------------
// pxs_delay_align_if
//   Stream and control bundle of the delay-align block.
//     RGBStr_i   stream into the delay line
//     dly_i      requested delay, sampled on a VS rising edge
//     RGBStr_o   delayed stream
//     dly_act_o  delay currently in force
//     filling_o  high while the output is blanked after a delay change
//   With PXS_DELAY_STATUS_EN defined, also carries:
//     frm_cnt_o  count of VS rising edges
//     upd_o      one-cycle pulse after dly_act_o changes
//   master: stream source / status sink.  slave: the delay line.
// ---------------------------------------------------------------------------
interface pxs_delay_align_if #(
    parameter int AW = 10
);
    import pxs_pkg::*;

    pxs_t          RGBStr_i;
    logic [AW-1:0] dly_i;
    pxs_t          RGBStr_o;
    logic [AW-1:0] dly_act_o;
    logic          filling_o;
`ifdef PXS_DELAY_STATUS_EN
    logic [15:0]   frm_cnt_o;
    logic          upd_o;

    modport master (output RGBStr_i, dly_i,
                    input  RGBStr_o, dly_act_o, filling_o, frm_cnt_o, upd_o);
    modport slave  (input  RGBStr_i, dly_i,
                    output RGBStr_o, dly_act_o, filling_o, frm_cnt_o, upd_o);
`else
    modport master (output RGBStr_i, dly_i,
                    input  RGBStr_o, dly_act_o, filling_o);
    modport slave  (input  RGBStr_i, dly_i,
                    output RGBStr_o, dly_act_o, filling_o);
`endif

endinterface

// File: rtl/pxs_dly_ram.sv
// ---------------------------------------------------------------------------
// pxs_dly_ram
//   Simple dual-port RAM, 2**AW words of W bits, one write port and one
//   synchronous read port on the same clock. Written to map onto block RAM.
//   Ports:
//     clk      clock
//     i_we     write enable
//     i_waddr  write address
//     i_wdata  write data
//     i_raddr  read address (data appears one clock later)
//     o_rdata  registered read data
// ---------------------------------------------------------------------------
module pxs_dly_ram #(
    parameter int AW = 10,
    parameter int W  = 26
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [0:(2**AW)-1];
    logic [W-1:0] r_rdata;

    // NOTE: no reset on the array or its read register -- a reset port would
    // stop the storage mapping onto block RAM, and stale contents are never
    // observed because the consumer blanks until fresh words have been written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pxs_delay_align.sv
// ---------------------------------------------------------------------------
// pxs_delay_align
//   Frame-safe programmable delay line for one 26-bit pixel stream. Matches
//   the latency of a bypass branch to a processed branch. The delay changes
//   only on a VS rising edge; after a change to a non-zero delay the output
//   is blanked while the line refills with words of the new frame.
//   Latency is D+1 clocks, D = dly_act_o.
//   Ports:
//     px_clk   pixel clock
//     rst_n    asynchronous active-low reset
//     bus      pxs_delay_align_if.slave (stream in/out, delay, status)
//   Optional feature macro: PXS_DELAY_STATUS_EN adds frm_cnt_o and upd_o on
//   the interface; datapath timing is the same with or without it.
// ---------------------------------------------------------------------------
module pxs_delay_align
    import pxs_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                  px_clk,
    input  logic                  rst_n,
    pxs_delay_align_if.slave      bus
);

    pxs_t          w_in;
    logic          w_vs_edge;
    logic          r_vs_q;

    dly_state_e    r_state,   w_state_nxt;
    logic [AW-1:0] r_dly_act, w_dly_nxt;
    logic [AW-1:0] r_cnt,     w_cnt_nxt;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] w_raddr;
    pxs_t          w_rdata;
    pxs_t          r_d1;
    pxs_t          r_out;
    pxs_t          w_out_nxt;

    assign w_in      = bus.RGBStr_i;
    assign w_vs_edge = w_in[PXS_VS_BIT] & ~r_vs_q;

    // The output for cycle t is registered from a read issued at t-2, so the
    // read slot is wptr-(D-1). D=0 and D=1 take register paths instead, which
    // also keeps the read slot off the slot being written.
    assign w_raddr = r_wptr - r_dly_act + AW'(1);

    pxs_dly_ram #(
        .AW (AW),
        .W  (PXS_W)
    ) u_ram (
        .clk     (px_clk),
        .i_we    (1'b1),
        .i_waddr (r_wptr),
        .i_wdata (w_in),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly_act;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_vs_edge) begin
                    w_dly_nxt = bus.dly_i;
                    // Going to zero needs no refill: the bypass register
                    // already holds the word of the new frame.
                    if (bus.dly_i != r_dly_act && bus.dly_i != '0) begin
                        w_state_nxt = ST_FILL;
                        w_cnt_nxt   = bus.dly_i;
                    end
                end
            end
            ST_FILL: begin
                if (w_vs_edge) begin
                    // A new frame while refilling restarts the blank window.
                    w_dly_nxt = bus.dly_i;
                    if (bus.dly_i != '0) begin
                        w_cnt_nxt = bus.dly_i;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end
                end else if (r_cnt == AW'(1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The output register is loaded for the next cycle, so both the blanking
    // and the path select use the next-cycle state and delay. That lets a new
    // delay apply to the very word that carried the VS edge.
    always_comb begin
        if (w_state_nxt == ST_FILL) begin
            w_out_nxt = PXS_BLANK;
        end else if (w_dly_nxt == '0) begin
            w_out_nxt = w_in;
        end else if (w_dly_nxt == AW'(1)) begin
            w_out_nxt = r_d1;
        end else begin
            w_out_nxt = w_rdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_q    <= 1'b0;
            r_state   <= ST_RUN;
            r_dly_act <= '0;
            r_cnt     <= '0;
            r_wptr    <= '0;
            r_d1      <= PXS_BLANK;
            r_out     <= PXS_BLANK;
        end else begin
            r_vs_q    <= w_in[PXS_VS_BIT];
            r_state   <= w_state_nxt;
            r_dly_act <= w_dly_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wptr    <= r_wptr + AW'(1);
            r_d1      <= w_in;
            r_out     <= w_out_nxt;
        end
    end

    assign bus.RGBStr_o  = r_out;
    assign bus.dly_act_o = r_dly_act;
    assign bus.filling_o = (r_state == ST_FILL);

`ifdef PXS_DELAY_STATUS_EN
    logic [15:0] r_frm_cnt;
    logic        r_upd;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frm_cnt <= '0;
            r_upd     <= 1'b0;
        end else begin
            if (w_vs_edge) begin
                r_frm_cnt <= r_frm_cnt + 16'd1;
            end
            r_upd <= (w_dly_nxt != r_dly_act);
        end
    end

    assign bus.frm_cnt_o = r_frm_cnt;
    assign bus.upd_o     = r_upd;
`endif

endmodule

// File: tb/tb_pxs_delay_align.sv
// ---------------------------------------------------------------------------
// tb_pxs_delay_align
//   Directed stimulus for pxs_delay_align. Each driven cycle pushes the
//   expected outputs for that cycle (from an input history and a behavioural
//   delay/blanking model) into a queue; a negedge monitor pops and compares.
//   Honours PXS_DELAY_STATUS_EN for the status outputs.
// ---------------------------------------------------------------------------
module tb_pxs_delay_align;
    import pxs_pkg::*;

    localparam int AW   = 10;
    localparam int HMAX = 4096;

    logic px_clk = 1'b0;
    logic rst_n  = 1'b0;

    pxs_delay_align_if #(.AW(AW)) bus ();

    pxs_delay_align #(.AW(AW)) dut (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        pxs_t          data;
        logic          fill;
        logic [AW-1:0] dly;
        logic          upd;
        logic [15:0]   frm;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    // Model state
    pxs_t        hist [HMAX];
    int          n           = 0;
    int          base        = 0;
    int          m_dly       = 0;
    int          blank_until = -1;
    logic        m_prev_vs   = 1'b0;
    logic        m_upd       = 1'b0;
    logic [15:0] m_frm       = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, n, act, req);
        end
    endtask

    // Drive one input word for the current cycle and queue what the DUT must
    // show during this cycle.
    task automatic drive_cycle(input logic vs, input int dly);
        pxs_t w;
        exp_t e;
        int   src;
        if (n >= HMAX) begin
            $display("FAIL hist_overflow at cycle %0d: actual=%0d required<%0d", n, n, HMAX);
            errors++;
            $fatal(1, "history overflow");
        end
        w = pxs_pack(vs, n[2], 8'(n), 8'(n >> 8), 8'(n * 3 + 1));
        bus.RGBStr_i = w;
        bus.dly_i    = AW'(dly);
        src    = n - m_dly - 1;
        e.fill = (n <= blank_until);
        e.data = e.fill ? PXS_BLANK : ((src < base) ? PXS_BLANK : hist[src]);
        e.dly  = AW'(m_dly);
        e.upd  = m_upd;
        e.frm  = m_frm;
        sb_q.push_back(e);
        hist[n] = w;
        m_upd   = 1'b0;
        if (vs && !m_prev_vs) begin
            m_frm = m_frm + 16'd1;
            if (e.fill || dly != m_dly) begin
                blank_until = n + dly;
            end
            if (dly != m_dly) begin
                m_upd = 1'b1;
            end
            m_dly = dly;
        end
        m_prev_vs = vs;
        n++;
    endtask

    task automatic step(input logic vs, input int dly);
        @(posedge px_clk);
        #1;
        drive_cycle(vs, dly);
    endtask

    task automatic release_reset(input int dly);
        @(posedge px_clk);
        #1;
        rst_n       = 1'b1;
        base        = n;
        m_dly       = 0;
        blank_until = n - 1;
        m_prev_vs   = 1'b0;
        m_upd       = 1'b0;
        m_frm       = '0;
        drive_cycle(1'b0, dly);
        mon_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},    32'(bus.RGBStr_o),  32'd0);
        check({tag, "_dly_act"}, 32'(bus.dly_act_o), 32'd0);
        check({tag, "_filling"}, 32'(bus.filling_o), 32'd0);
`ifdef PXS_DELAY_STATUS_EN
        check({tag, "_frm_cnt"}, 32'(bus.frm_cnt_o), 32'd0);
        check({tag, "_upd"},     32'(bus.upd_o),     32'd0);
`endif
    endtask

    // Scoreboard monitor
    always @(negedge px_clk) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow at cycle %0d: actual=empty required=entry", n);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("data",    32'(bus.RGBStr_o),  32'(e.data));
                check("filling", 32'(bus.filling_o), 32'(e.fill));
                check("dly_act", 32'(bus.dly_act_o), 32'(e.dly));
`ifdef PXS_DELAY_STATUS_EN
                check("upd",     32'(bus.upd_o),     32'(e.upd));
                check("frm_cnt", 32'(bus.frm_cnt_o), 32'(e.frm));
`endif
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bus.RGBStr_i = '0;
        bus.dly_i    = '0;
        repeat (2) @(posedge px_clk);
        #1;
        check_reset_outputs("por");
        release_reset(0);

        // 1: D=0 pass-through, 1-cycle latency
        repeat (8) step(1'b0, 0);

        // 2: D=5 at a VS edge; mid-frame request of 9 must be ignored
        step(1'b1, 5);
        step(1'b1, 5);
        repeat (4)  step(1'b0, 5);
        repeat (14) step(1'b0, 9);

        // 3: D 5 -> 2
        step(1'b1, 2);
        repeat (13) step(1'b0, 2);

        // 5: second VS edge during FILL restarts the blank count
        step(1'b1, 7);
        step(1'b0, 7);
        step(1'b0, 7);
        step(1'b1, 4);
        repeat (12) step(1'b0, 4);

        // D=1 register path
        step(1'b1, 1);
        repeat (6) step(1'b0, 1);

        // 4: maximum delay across pointer wrap
        step(1'b1, 1023);
        repeat (1100) step(1'b0, 1023);

        // Back to D=0 with no blanking
        step(1'b1, 0);
        repeat (6) step(1'b0, 0);

        // 6: asynchronous reset in the middle of FILL
        step(1'b1, 6);
        repeat (3) step(1'b0, 6);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb_q.delete();
        release_reset(6);
        repeat (8) step(1'b0, 6);

        @(negedge px_clk);
        #1;
        mon_en = 1'b0;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: actual=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
